// File: rtl/voice_allocator_pkg.sv
// Shared defaults and the per-voice record for the voice allocator.
package voice_allocator_pkg;

  localparam int DEF_NUM_KEYS   = 8;
  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_AGE_W      = 4;

  // Record fields are sized for the largest supported configuration
  // (up to 256 keys, AGE_W up to 8); narrower configs leave upper bits zero.
  localparam int KEY_MAX_W = 8;
  localparam int AGE_MAX_W = 8;

  typedef struct packed {
    logic                 gate;
    logic [KEY_MAX_W-1:0] key;
    logic [AGE_MAX_W-1:0] age;
  } voice_t;

  function automatic logic [AGE_MAX_W-1:0] age_sat(input int age_w);
    return AGE_MAX_W'((1 << age_w) - 1);
  endfunction

endpackage

// File: rtl/voice_allocator_voice_select.sv
// Picks the lowest free voice, or the oldest gated voice when none is free.
module voice_select
  import voice_allocator_pkg::*;
#(
  parameter int  NUM_VOICES = DEF_NUM_VOICES,
  localparam int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic [NUM_VOICES-1:0]                gates,
  input  logic [NUM_VOICES-1:0][AGE_MAX_W-1:0] ages,
  output logic [IDX_W-1:0]                     idx,
  output logic                                 steal
);

  logic                 found;
  logic [IDX_W-1:0]     free_idx;
  logic [IDX_W-1:0]     old_idx;
  logic [AGE_MAX_W-1:0] old_age;

  always_comb begin
    found    = 1'b0;
    free_idx = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!gates[v] && !found) begin
        free_idx = IDX_W'(v);
        found    = 1'b1;
      end
    end

    // Strict '>' keeps the lowest index on equal ages.
    old_idx = '0;
    old_age = ages[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (ages[v] > old_age) begin
        old_age = ages[v];
        old_idx = IDX_W'(v);
      end
    end

    steal = ~found;
    idx   = found ? free_idx : old_idx;
  end

endmodule

// File: rtl/voice_allocator.sv
// Key scanner that assigns pressed keys to a shared pool of oscillator voices.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int  NUM_KEYS   = DEF_NUM_KEYS,
  parameter int  NUM_VOICES = DEF_NUM_VOICES,
  parameter int  AGE_W      = DEF_AGE_W,
  localparam int KEY_W      = $clog2(NUM_KEYS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic [NUM_KEYS-1:0]         keys,
  output logic [NUM_VOICES-1:0]       voice_gate,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [NUM_VOICES-1:0]       voice_start,
  output logic                        steal
);

  localparam int                   IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_MAX_W-1:0] AGE_SAT  = age_sat(AGE_W);
  localparam logic [KEY_W-1:0]     LAST_KEY = KEY_W'(NUM_KEYS - 1);

  logic [KEY_W-1:0]                     scan_q, scan_d;
  logic [NUM_KEYS-1:0]                  key_state_q, key_state_d;
  voice_t [NUM_VOICES-1:0]              voice_q, voice_d;
  logic [NUM_VOICES-1:0]                start_q, start_d;
  logic                                 steal_q, steal_d;

  logic [NUM_VOICES-1:0]                gates;
  logic [NUM_VOICES-1:0][AGE_MAX_W-1:0] ages;
  logic [IDX_W-1:0]                     sel_idx;
  logic                                 sel_steal;
  logic                                 key_now, key_was;
  logic [KEY_MAX_W-1:0]                 scan_key;

  always_comb begin
    gates     = '0;
    ages      = '0;
    voice_key = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      gates[v]                   = voice_q[v].gate;
      ages[v]                    = voice_q[v].age;
      voice_key[v*KEY_W +: KEY_W] = voice_q[v].key[KEY_W-1:0];
    end
  end

  voice_select #(.NUM_VOICES(NUM_VOICES)) u_sel (
    .gates (gates),
    .ages  (ages),
    .idx   (sel_idx),
    .steal (sel_steal)
  );

  always_comb begin
    scan_d      = scan_q;
    key_state_d = key_state_q;
    voice_d     = voice_q;
    start_d     = '0;
    steal_d     = 1'b0;
    key_now     = keys[scan_q];
    key_was     = key_state_q[scan_q];
    scan_key    = KEY_MAX_W'(scan_q);

    if (ena) begin
      scan_d = (scan_q == LAST_KEY) ? '0 : scan_q + KEY_W'(1);
      if (key_now && !key_was) begin
        key_state_d[scan_q] = 1'b1;
        steal_d             = sel_steal;
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (v == int'(sel_idx)) begin
            voice_d[v].gate = 1'b1;
            voice_d[v].key  = scan_key;
            voice_d[v].age  = '0;
            start_d[v]      = 1'b1;
          end else if (voice_q[v].gate && voice_q[v].age != AGE_SAT) begin
            voice_d[v].age = voice_q[v].age + AGE_MAX_W'(1);
          end
        end
      end else if (!key_now && key_was) begin
        // A key whose voice was stolen matches nothing here: no gate to drop.
        key_state_d[scan_q] = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (voice_q[v].gate && voice_q[v].key == scan_key) voice_d[v].gate = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q      <= '0;
      key_state_q <= '0;
      voice_q     <= '0;
      start_q     <= '0;
      steal_q     <= 1'b0;
    end else begin
      scan_q      <= scan_d;
      key_state_q <= key_state_d;
      voice_q     <= voice_d;
      start_q     <= start_d;
      steal_q     <= steal_d;
    end
  end

  assign voice_gate  = gates;
  assign voice_start = start_q;
  assign steal       = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench: expected voice events are queued with each stimulus step and matched as they appear.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [7:0]  keys;
  logic [3:0]  voice_gate;
  logic [11:0] voice_key;
  logic [3:0]  voice_start;
  logic        steal;

  always #5 clk = ~clk;

  voice_allocator dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .keys        (keys),
    .voice_gate  (voice_gate),
    .voice_key   (voice_key),
    .voice_start (voice_start),
    .steal       (steal)
  );

  typedef struct packed {
    logic [3:0]  start;
    logic        stl;
    logic [3:0]  gate;
    logic [11:0] keyv;
  } ev_t;

  ev_t        exp_q[$];
  int         tests = 0;
  int         fails = 0;
  logic       mon_en = 1'b0;
  logic [3:0] prev_gate = 4'h0;
  int         scan_exp = 0;

  // Scan position as the interface defines it: reset to 0, +1 per ena cycle, wrap at 8.
  always @(posedge clk) begin
    if (rst) scan_exp <= 0;
    else if (ena) scan_exp <= (scan_exp == 7) ? 0 : scan_exp + 1;
  end

  // An event is any start pulse or any gate falling.
  always @(negedge clk) begin
    ev_t obs;
    ev_t exp;
    obs = {voice_start, steal, voice_gate, voice_key};
    if (mon_en && (voice_start != 4'h0 || (prev_gate & ~voice_gate) != 4'h0)) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL unexpected_event observed=%h required=none", obs);
      end else begin
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
          fails++;
          $error("FAIL event observed=%h required=%h", obs, exp);
        end
      end
    end
    prev_gate = voice_gate;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] st, input logic sl, input logic [3:0] g,
                      input logic [2:0] k0, input logic [2:0] k1,
                      input logic [2:0] k2, input logic [2:0] k3);
    ev_t e;
    e = {st, sl, g, k3, k2, k1, k0};
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h required=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_empty(input string tag);
    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL %s observed=%0d_pending required=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst  = 1'b1;
    ena  = 1'b1;
    keys = 8'h00;
    tick(3);
    @(negedge clk);
    check("rst_gate",  32'(voice_gate),  32'h0);
    check("rst_key",   32'(voice_key),   32'h0);
    check("rst_start", 32'(voice_start), 32'h0);
    check("rst_steal", 32'(steal),       32'h0);
    tick(1);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single key 2 lands on voice 0.
    push(4'b0001, 1'b0, 4'b0001, 3'd2, 3'd0, 3'd0, 3'd0);
    keys = 8'h04;
    tick(9);
    chk_empty("single_key");

    // Fresh reset, four keys fill the pool in key order.
    mon_en = 1'b0;
    rst    = 1'b1;
    keys   = 8'h00;
    tick(2);
    rst    = 1'b0;
    mon_en = 1'b1;
    push(4'b0001, 1'b0, 4'b0001, 3'd0, 3'd0, 3'd0, 3'd0);
    push(4'b0010, 1'b0, 4'b0011, 3'd0, 3'd1, 3'd0, 3'd0);
    push(4'b0100, 1'b0, 4'b0111, 3'd0, 3'd1, 3'd2, 3'd0);
    push(4'b1000, 1'b0, 4'b1111, 3'd0, 3'd1, 3'd2, 3'd3);
    keys = 8'h0F;
    tick(10);
    chk_empty("fill_pool");

    // Fifth key steals oldest voice 0 with no gate gap.
    push(4'b0001, 1'b1, 4'b1111, 3'd5, 3'd1, 3'd2, 3'd3);
    keys = 8'h2F;
    tick(10);
    chk_empty("steal_oldest");

    // Release key 1: voice 1 drops, key held; then key 6 takes voice 1.
    push(4'b0000, 1'b0, 4'b1101, 3'd5, 3'd1, 3'd2, 3'd3);
    keys = 8'h2D;
    tick(10);
    chk_empty("release");
    push(4'b0010, 1'b0, 4'b1111, 3'd5, 3'd6, 3'd2, 3'd3);
    keys = 8'h6D;
    tick(10);
    chk_empty("reuse_free");

    // Freeze with key 3 next to scan; change keys while frozen.
    for (int i = 0; i < 8 && scan_exp != 3; i++) tick(1);
    check("freeze_align", 32'(scan_exp), 32'd3);
    ena = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) keys = 8'hE9;
      @(negedge clk);
      check("frozen_outputs", 32'({voice_gate, voice_key, voice_start, steal}),
            32'({4'hF, 3'd3, 3'd2, 3'd6, 3'd5, 4'h0, 1'b0}));
      @(posedge clk);
      #1;
    end
    // Key 7 is scanned before key 2's release, so it steals oldest voice 2;
    // the later key 2 release then finds no voice to drop.
    push(4'b0100, 1'b1, 4'b1111, 3'd5, 3'd6, 3'd7, 3'd3);
    ena = 1'b1;
    tick(12);
    chk_empty("resume_scan_order");

    // One-cycle reset mid-scan with all voices gated.
    mon_en = 1'b0;
    keys   = 8'h01;
    rst    = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_gate",  32'(voice_gate),  32'h0);
    check("midrst_key",   32'(voice_key),   32'h0);
    check("midrst_start", 32'(voice_start), 32'h0);
    check("midrst_steal", 32'(steal),       32'h0);
    push(4'b0001, 1'b0, 4'b0001, 3'd0, 3'd0, 3'd0, 3'd0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rescan_first", 32'(voice_start), 32'h1);
    tick(10);
    chk_empty("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 NUM_KEYS, 8, number of key inputs scanned; SHALL be >= 2.
REQ-002 NUM_VOICES, 4, number of oscillator voices shared among keys; SHALL be >= 1.
REQ-003 AGE_W, 4, width of the per-voice saturating age counter.
REQ-004 KEY_W is derived as $clog2(NUM_KEYS) and SHALL NOT be overridable.
REQ-005 clk  input  1  clock.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 ena  input  1  scan enable; all state advances only on cycles with ena=1.
REQ-008 keys  input  NUM_KEYS  debounced key levels, 1=pressed.
REQ-009 voice_gate  output  NUM_VOICES  1=voice is sounding.
REQ-010 voice_key  output  NUM_VOICES*KEY_W  key index per voice; voice v occupies bits [v*KEY_W +: KEY_W].
REQ-011 voice_start  output  NUM_VOICES  one-cycle pulse: voice v was (re)assigned, used for oscillator phase reset.
REQ-012 steal  output  1  one-cycle pulse: an allocation took a voice that was already gated.

Function
REQ-013 A scan index SHALL advance by one key per ena cycle, from 0 to NUM_KEYS-1, then wrap to 0.
REQ-014 Each scanned key k SHALL be compared with an internal accepted state key_state[k].
REQ-015 keys[k]=1 and key_state[k]=0 is a note-on; key_state[k] SHALL be set and one voice allocated.
REQ-016 keys[k]=0 and key_state[k]=1 is a note-off; key_state[k] SHALL be cleared and every voice with gate=1 and voice_key=k released.
REQ-017 Allocation SHALL pick the lowest-index voice with gate=0.
REQ-018 If no voice is free, allocation SHALL steal the gated voice with the largest age, lowest index on ties, and pulse steal.
REQ-019 On allocation, all other gated voices SHALL have age incremented, saturating at 2^AGE_W-1.
REQ-020 On allocation, the chosen voice's age SHALL be set to 0.
REQ-021 Ungated voices SHALL not age.
REQ-022 Output latency SHALL be 1 clk after the scan cycle: voice_gate[v]=1, voice_key[v]=k and voice_start[v]=1 for exactly that cycle; steal is co-timed.
REQ-023 On steal, voice_gate[v] SHALL remain 1 without a low cycle, and voice_key[v] SHALL change.
REQ-024 A stolen-from key SHALL keep key_state=1 with no voice and SHALL NOT be retriggered until it is released and pressed again.
REQ-025 On release, voice_gate[v] SHALL fall 1 clk after the scan cycle, and voice_key[v] SHALL hold its last value.
REQ-026 With ena=0: the scan index, key_state and ages SHALL be frozen; voice_start and steal SHALL be 0; voice_gate and voice_key SHALL hold.
REQ-027 At most one allocation or release event SHALL occur per clk; a key SHALL never hold more than one voice.
REQ-028 Worst-case detection latency SHALL be NUM_KEYS ena cycles plus 1 clk.

Reset
REQ-029 While rst=1: voice_gate=0, voice_key=0, voice_start=0, steal=0, scan index=0, key_state=0, all ages=0.
REQ-030 Reset SHALL take priority over ena and SHALL clear in-progress state mid-scan.
REQ-031 Keys still held after reset SHALL be detected as fresh note-ons.

Structure
REQ-032 The default parameter values and the voice record typedef (gate, key, age) SHALL live in the shared synth package.
REQ-033 Free-voice and oldest-voice selection SHALL be one combinational sub-module, voice_select, taking gates and ages and returning the index plus a steal flag.
REQ-034 The scanner and registers SHALL remain in voice_allocator.

Verification (NUM_KEYS=8, NUM_VOICES=4, ena=1 unless stated)
REQ-035 Reset, then keys=8'h04: within 9 clk voice_gate=4'b0001, voice_key[0]=2, a single voice_start[0] pulse, steal stays 0.
REQ-036 Reset, then keys=8'h0F: voices 0..3 hold keys 0..3, voice_gate=4'b1111, four separate voice_start pulses in key order.
REQ-037 Continue from REQ-036 and set keys=8'h2F: voice 0 (age 3) is stolen, voice_key[0]=5, steal and voice_start[0] pulse together, voice_gate stays 4'b1111.
REQ-038 Continue and set keys=8'h2D: voice_gate[1] falls, voice_key[1] stays 1; then keys=8'h6D: voice 1 takes key 6 with no steal.
REQ-039 Drop ena to 0 for 20 clk while changing keys: outputs are unchanged and pulses stay 0; after ena returns, the changes are processed in scan order.
REQ-040 Assert rst for 1 clk mid-scan with 4 gates active and keys=8'h01: all outputs are 0 the next cycle, then key 0 is reallocated to voice 0.
